// File: rtl/mouse_cell_picker.sv
// Maps the synchronised mouse pointer onto the Minesweeper grid.
// Emits one handshaked click event per press and a live hover cell.
//
// Ports:
//   clk74MHz, rst_n           clock, async active-low reset
//   mouse_xpos/ypos [11:0]    pointer position in pixels
//   left, right               button levels
//   event_valid/ready         click event handshake
//   event_type [1:0]          01 reveal, 10 flag, 11 chord
//   event_col/row [4:0]       click target cell
//   hover_valid, col/row      cell under the pointer
module mouse_cell_picker #(
    parameter int BOARD_X0  = 192,
    parameter int BOARD_Y0  = 96,
    parameter int CELL_SIZE = 40,
    parameter int GRID_COLS = 16,
    parameter int GRID_ROWS = 16
) (
    input  logic        clk74MHz,
    input  logic        rst_n,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        left,
    input  logic        right,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [1:0]  event_type,
    output logic [4:0]  event_col,
    output logic [4:0]  event_row,
    output logic        hover_valid,
    output logic [4:0]  hover_col,
    output logic [4:0]  hover_row
);

    localparam logic [11:0] X0   = 12'(BOARD_X0);
    localparam logic [11:0] Y0   = 12'(BOARD_Y0);
    localparam logic [12:0] CS   = 13'(CELL_SIZE);
    localparam logic [5:0]  COLS = 6'(GRID_COLS);
    localparam logic [5:0]  ROWS = 6'(GRID_ROWS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        ACK
    } state_t;

    state_t state_q, state_d;

    logic        left_q, left_q2, right_q, right_q2;
    logic        slot_full;
    logic [1:0]  slot_type;
    logic [11:0] slot_x, slot_y;

    logic        job_click;
    logic [1:0]  job_type;
    logic [11:0] job_x, job_y;
    logic [12:0] rx, ry;
    logic [5:0]  qx, qy;
    logic        out_q;

    logic [1:0]  rise;
    logic        start_click, start_hover;
    logic        done_x, done_y, at_limit, finish, out_f;

    assign rise = {right_q & ~right_q2, left_q & ~left_q2};

    // A full slot preempts any hover work; click jobs run to completion.
    assign start_click = slot_full &&
        (state_q == IDLE ||
         ((state_q == LOAD || state_q == DIV) && !job_click));
    assign start_hover = (state_q == IDLE) && !slot_full;

    assign done_x   = rx < CS;
    assign done_y   = ry < CS;
    assign at_limit = (qx == COLS) || (qy == ROWS);
    assign out_f    = out_q || at_limit;
    assign finish   = (state_q == DIV) && !start_click &&
                      (out_q || (done_x && done_y) || at_limit);

    always_ff @(posedge clk74MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: state_d = start_click ? LOAD : DIV;
            DIV: begin
                if (start_click) begin
                    state_d = LOAD;
                end else if (finish) begin
                    state_d = (job_click && !out_f) ? ACK : IDLE;
                end
            end
            ACK: begin
                if (event_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk74MHz or negedge rst_n) begin
        if (!rst_n) begin
            // History resets high so a button held through reset is ignored.
            left_q      <= 1'b1;
            left_q2     <= 1'b1;
            right_q     <= 1'b1;
            right_q2    <= 1'b1;
            slot_full   <= 1'b0;
            slot_type   <= 2'b00;
            slot_x      <= '0;
            slot_y      <= '0;
            job_click   <= 1'b0;
            job_type    <= 2'b00;
            job_x       <= '0;
            job_y       <= '0;
            rx          <= '0;
            ry          <= '0;
            qx          <= '0;
            qy          <= '0;
            out_q       <= 1'b0;
            event_valid <= 1'b0;
            event_type  <= 2'b00;
            event_col   <= '0;
            event_row   <= '0;
            hover_valid <= 1'b0;
            hover_col   <= '0;
            hover_row   <= '0;
        end else begin
            left_q   <= left;
            left_q2  <= left_q;
            right_q  <= right;
            right_q2 <= right_q;

            if (start_click) begin
                slot_full <= 1'b0;
            end else if (|rise && !slot_full) begin
                slot_full <= 1'b1;
                slot_type <= rise;
                slot_x    <= mouse_xpos;
                slot_y    <= mouse_ypos;
            end

            if (start_click) begin
                job_click <= 1'b1;
                job_type  <= slot_type;
                job_x     <= slot_x;
                job_y     <= slot_y;
            end else if (start_hover) begin
                job_click <= 1'b0;
                job_x     <= mouse_xpos;
                job_y     <= mouse_ypos;
            end

            if (state_q == LOAD && !start_click) begin
                out_q <= (job_x < X0) || (job_y < Y0);
                rx    <= {1'b0, job_x} - {1'b0, X0};
                ry    <= {1'b0, job_y} - {1'b0, Y0};
                qx    <= '0;
                qy    <= '0;
            end

            // Restoring division by repeated subtraction, both axes at once.
            if (state_q == DIV && !start_click && !finish) begin
                if (!done_x) begin
                    rx <= rx - CS;
                    qx <= qx + 6'd1;
                end
                if (!done_y) begin
                    ry <= ry - CS;
                    qy <= qy + 6'd1;
                end
            end

            if (finish) begin
                hover_valid <= !out_f;
                if (!out_f) begin
                    hover_col <= qx[4:0];
                    hover_row <= qy[4:0];
                end
                if (job_click && !out_f) begin
                    event_valid <= 1'b1;
                    event_type  <= job_type;
                    event_col   <= qx[4:0];
                    event_row   <= qy[4:0];
                end
            end

            if (state_q == ACK && event_ready) begin
                event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mouse_cell_picker.sv
// Directed bench for mouse_cell_picker with default parameters.
// Hand-computed cell coordinates and click latencies.
module tb_mouse_cell_picker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] mx = 12'd0;
    logic [11:0] my = 12'd0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        event_ready = 1'b0;
    logic        event_valid;
    logic [1:0]  event_type;
    logic [4:0]  event_col, event_row;
    logic        hover_valid;
    logic [4:0]  hover_col, hover_row;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    mouse_cell_picker dut (
        .clk74MHz   (clk),
        .rst_n      (rst_n),
        .mouse_xpos (mx),
        .mouse_ypos (my),
        .left       (left),
        .right      (right),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_type (event_type),
        .event_col  (event_col),
        .event_row  (event_row),
        .hover_valid(hover_valid),
        .hover_col  (hover_col),
        .hover_row  (hover_row)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_event(input int maxc, output int cnt);
        cnt = 0;
        while (cnt < maxc) begin
            @(posedge clk);
            #1;
            cnt++;
            if (event_valid) break;
        end
    endtask

    task automatic no_event(input string tag, input int c);
        int seen;
        seen = 0;
        repeat (c) begin
            @(posedge clk);
            #1;
            if (event_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic do_ack(input string tag);
        event_ready = 1'b1;
        @(posedge clk);
        #1;
        event_ready = 1'b0;
        chk(tag, {31'd0, event_valid}, 32'd0);
    endtask

    function automatic logic [31:0] ev();
        return {17'd0, event_type, event_col, event_row};
    endfunction

    function automatic logic [31:0] hv();
        return {21'd0, hover_valid, hover_col, hover_row};
    endfunction

    function automatic logic [31:0] allout();
        return {8'd0, event_valid, event_type, event_col, event_row,
                hover_valid, hover_col, hover_row};
    endfunction

    initial begin
        int bad;
        // Reset with left held high
        mx = 12'd275;
        my = 12'd137;
        left = 1'b1;
        step(3);
        chk("reset_outputs", allout(), 32'd0);
        rst_n = 1'b1;
        no_event("held_through_reset", 30);
        chk("hover_after_reset", hv(), {21'd0, 1'b1, 5'd2, 5'd1});

        // Re-press: reveal at (275,137) -> col 2 row 1, N+6
        left = 1'b0;
        step(3);
        left = 1'b1;
        wait_event(40, n);
        chk("reveal_latency", n, 7);
        chk("reveal_fields", ev(), {17'd0, 2'b01, 5'd2, 5'd1});
        chk("reveal_hover", hv(), {21'd0, 1'b1, 5'd2, 5'd1});
        do_ack("reveal_ack");
        left = 1'b0;
        step(3);

        // Chord at (831,735) -> col 15 row 15, N+19
        mx = 12'd831;
        my = 12'd735;
        left = 1'b1;
        right = 1'b1;
        wait_event(40, n);
        chk("chord_latency", n, 20);
        chk("chord_fields", ev(), {17'd0, 2'b11, 5'd15, 5'd15});
        chk("chord_hover", hv(), {21'd0, 1'b1, 5'd15, 5'd15});
        do_ack("chord_ack");
        left = 1'b0;
        right = 1'b0;
        step(3);

        // Right press at x=832 (past last column)
        mx = 12'd832;
        my = 12'd137;
        right = 1'b1;
        no_event("x832_no_event", 40);
        chk("x832_hover", {31'd0, hover_valid}, 32'd0);
        right = 1'b0;
        step(3);

        // Right press at x=191 (left of board)
        mx = 12'd191;
        right = 1'b1;
        no_event("x191_no_event", 40);
        chk("x191_hover", {31'd0, hover_valid}, 32'd0);
        right = 1'b0;
        step(3);

        // Flag at board origin
        mx = 12'd192;
        my = 12'd96;
        right = 1'b1;
        wait_event(40, n);
        chk("flag_latency", n, 5);
        chk("flag_fields", ev(), {17'd0, 2'b10, 5'd0, 5'd0});
        do_ack("flag_ack");
        right = 1'b0;
        step(3);

        // Back-pressure: second press queued, third dropped
        mx = 12'd275;
        my = 12'd137;
        left = 1'b1;
        wait_event(40, n);
        chk("bp_first_latency", n, 7);
        bad = 0;
        left = 1'b0;
        mx = 12'd400;
        my = 12'd300;
        for (int i = 0; i < 50; i++) begin
            if (i == 3) left = 1'b1;
            if (i == 6) begin
                left = 1'b0;
                mx = 12'd600;
                my = 12'd600;
            end
            if (i == 9) left = 1'b1;
            step(1);
            if (!event_valid || ev() != {17'd0, 2'b01, 5'd2, 5'd1})
                bad++;
        end
        chk("bp_first_stable", bad, 0);
        do_ack("bp_first_ack");
        left = 1'b0;
        wait_event(40, n);
        chk("bp_second_seen", {31'd0, event_valid}, 32'd1);
        chk("bp_second_fields", ev(), {17'd0, 2'b01, 5'd5, 5'd5});
        do_ack("bp_second_ack");
        no_event("bp_third_dropped", 40);
        chk("bp_hover_live", hv(), {21'd0, 1'b1, 5'd10, 5'd12});

        // Reset during DIV of a click
        mx = 12'd831;
        my = 12'd735;
        left = 1'b1;
        step(9);
        rst_n = 1'b0;
        #1;
        chk("mid_div_reset", allout(), 32'd0);
        step(2);
        rst_n = 1'b1;
        no_event("after_mid_reset", 40);
        chk("hover_after_mid", hv(), {21'd0, 1'b1, 5'd15, 5'd15});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_cell_picker.md
# mouse_cell_picker

Game-side consumer of the mouse peripheral, running in the 74 MHz pixel/game domain directly downstream of the mouse top level. It takes the already-synchronised mouse position and button levels and maps the pointer onto the Minesweeper board grid. It emits one handshaked click event per button press (reveal, flag, or chord) carrying the target cell. It also keeps a continuously refreshed hover cell for the cursor/highlight renderer.

## Interface
Parameters:
- BOARD_X0, 192: pixel x of the board's left edge
- BOARD_Y0, 96: pixel y of the board's top edge
- CELL_SIZE, 40: cell edge in pixels, 1..255
- GRID_COLS, 16: columns, 1..32
- GRID_ROWS, 16: rows, 1..32

Ports:
- clk74MHz  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- mouse_xpos  in  12  pointer x, unsigned pixels
- mouse_ypos  in  12  pointer y, unsigned pixels
- left  in  1  left button level
- right  in  1  right button level
- event_valid  out  1  click event available
- event_ready  in  1  consumer accepts event
- event_type  out  2  01 reveal (left), 10 flag (right), 11 chord (both)
- event_col  out  5  target column
- event_row  out  5  target row
- hover_valid  out  1  pointer is over the board
- hover_col  out  5  hovered column
- hover_row  out  5  hovered row

## Operation
- Button history: left_q/right_q and left_q2/right_q2, a two-stage history per button. Both stages reset to 1, so a button held through reset release produces no event.
- Rise detected when left_q & ~left_q2. Same rule for right.
- Pending slot: one-deep. It holds a type and a captured x/y.
  - On a rise, the slot is written if empty. Type comes from the buttons rising that cycle; simultaneous left and right rises give 11.
  - x/y are the mouse_xpos/mouse_ypos values sampled on that write edge.
  - A rise while the slot is full is dropped.
- FSM states: IDLE, LOAD, DIV, ACK. One job type is either HOVER or CLICK.
- IDLE:
  - If the slot is full, go to LOAD as a CLICK job and clear the slot.
  - Otherwise go to LOAD as a HOVER job using live mouse_xpos/mouse_ypos.
- Abort rule: in LOAD or DIV of a HOVER job, a full slot forces an immediate transition to LOAD of a CLICK job. The hover job is abandoned and the hover outputs keep their old values.
- LOAD:
  - Set out = 1 if x < BOARD_X0 or y < BOARD_Y0.
  - Otherwise rx = x − BOARD_X0 and ry = y − BOARD_Y0 (13-bit unsigned), with qx = qy = 0.
  - Next state is DIV.
- DIV, one step per cycle, evaluated in parallel for both axes:
  - If rx ≥ CELL_SIZE then rx −= CELL_SIZE and qx++. Same rule for ry/qy.
  - Finish when both remainders are < CELL_SIZE, or when qx == GRID_COLS or qy == GRID_ROWS (in which case out = 1). A job with out = 1 in LOAD finishes on its first DIV cycle.
  - The cycle count is max(qx,qy)+1, with a worst case of max(GRID_COLS,GRID_ROWS)+1.
- Finish of a HOVER job:
  - hover_valid = ~out. hover_col/row = qx/qy when in range; otherwise they hold their previous values.
  - Next state is IDLE.
- Finish of a CLICK job:
  - Hover outputs are updated identically.
  - If in range, load event_type/col/row, assert event_valid, and go to ACK.
  - If out of range, the click is discarded and the FSM goes to IDLE.
- ACK:
  - event_valid and the event fields stay stable until a clock edge with event_ready = 1. At that edge event_valid drops and the FSM goes to IDLE.
  - Hover refresh is paused. The pending slot may still fill.
- Asynchronous reset, including mid-job: every output is 0, FSM is IDLE, the slot is empty, and the in-flight job or event is lost.

## Timing
- Click latency: the button is first sampled high at edge N, and the slot is written at N+1. LOAD is entered at N+2 from IDLE or from any HOVER state. DIV begins at N+3 and event_valid rises at edge N+4+max(qx,qy).
- Latency is longer only when the FSM is in ACK or in an in-progress CLICK job at N+2.
- Hover refresh period while idle of clicks: max(qx,qy)+3 cycles (IDLE, LOAD, DIV).
- event_ready is sampled only while event_valid = 1. The event is never retracted before acceptance.
- A slot full during ACK is serviced on the cycle after IDLE, i.e. LOAD two edges after the ACK edge.

## Test plan
With default parameters:
- Reset, then hold left = 1 at rst_n release → no event ever. After release and re-press, one event.
- Mouse at (275,137) with a left press at edge N → event_valid at N+6 with type 01, col 2, row 1. Hover shows valid, 2, 1.
- Left and right rising at the same sample with the mouse at (831,735) → type 11, col 15, row 15, at N+4+15.
- Right press at x = 832, then x = 191 → no event, hover_valid = 0. At (192,96) → type 10, col 0, row 0.
- event_ready held 0 for 50 cycles while a second press occurs and a third press is dropped:
  - The first event stays stable.
  - After ready, exactly one more event follows, carrying the second press's coordinates.
- Drop rst_n low during DIV of a click → all outputs 0 immediately, and no event after release.
